// File: rtl/ram1p_clear_seq_pkg.sv
// Shared types for the single-port SRAM clear sequencer.
package ram1p_clear_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram1p_clear_state_t;

  // One byte-enable bit per started byte of the word.
  function automatic int bwe_bits(input int width);
    return (width - 1) / 8 + 1;
  endfunction

endpackage

// File: rtl/ram1p_clear_cnt.sv
// Sweep address counter: async reset, sync clear (wins over enable), last-word flag.
module ram1p_clear_cnt #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] cnt,
  output logic          last
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign last = (cnt == AW'(DEPTH - 1));

endmodule

// File: rtl/ram1p_clear_seq.sv
// Arbitrates one SRAM port between a cache client and a CLEAR_VALUE sweep engine.
// Optional: define RAM1P_CLEAR_ABORT_EN to add the clear_abort input.
module ram1p_clear_seq
  import ram1p_clear_seq_pkg::*;
#(
  parameter int               DEPTH          = 64,
  parameter int               WIDTH          = 44,
  parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter bit               CLEAR_ON_RESET = 1'b1,
  localparam int              AW             = $clog2(DEPTH),
  localparam int              BW             = bwe_bits(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_ce,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_din,
  input  logic             req_we,
  input  logic [BW-1:0]    req_bwe,
  output logic             req_ready,
  output logic [WIDTH-1:0] req_dout,
  output logic             req_rvalid,
  input  logic             clear_start,
`ifdef RAM1P_CLEAR_ABORT_EN
  input  logic             clear_abort,
`endif
  output logic             clear_busy,
  output logic             clear_done,
  output logic             ram_ce,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_din,
  output logic             ram_we,
  output logic [BW-1:0]    ram_bwe,
  input  logic [WIDTH-1:0] ram_dout
);

  localparam ram1p_clear_state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  ram1p_clear_state_t state, nxt;
  logic          cnt_clr, cnt_en, last, done_nxt, abort, busy;
  logic [AW-1:0] cnt;

`ifdef RAM1P_CLEAR_ABORT_EN
  assign abort = clear_abort;
`else
  assign abort = 1'b0;
`endif

  ram1p_clear_cnt #(.DEPTH(DEPTH), .AW(AW)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (cnt),
    .last (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RST_STATE;
      clear_done <= 1'b0;
      req_rvalid <= 1'b0;
    end else begin
      state      <= nxt;
      clear_done <= done_nxt;
      req_rvalid <= req_ce & req_ready & ~req_we;
    end
  end

  always_comb begin
    nxt      = state;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    done_nxt = 1'b0;
    unique case (state)
      IDLE: if (clear_start) begin
        nxt     = CLEAR;
        cnt_clr = 1'b1;
      end
      CLEAR: begin
        cnt_en = 1'b1;
        // Abort still writes the current word but suppresses the done pulse.
        if (abort) begin
          nxt     = IDLE;
          cnt_clr = 1'b1;
        end else if (last) begin
          nxt      = IDLE;
          cnt_clr  = 1'b1;
          done_nxt = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Reset gates the strobes combinationally so an interrupted sweep stops writing at once.
  always_comb begin
    busy       = (state == CLEAR);
    clear_busy = busy;
    req_ready  = ~busy & ~reset;
    req_dout   = ram_dout;
    ram_ce     = ~reset & (busy | req_ce);
    ram_we     = ~reset & (busy | req_we);
    ram_addr   = busy ? cnt         : req_addr;
    ram_din    = busy ? CLEAR_VALUE : req_din;
    ram_bwe    = busy ? '1          : req_bwe;
  end

endmodule
